// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR datapath.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Accumulator width that holds TAPS full-scale products without wrapping.
  function automatic int unsigned acc_width(input int unsigned taps,
                                            input int unsigned dw,
                                            input int unsigned cw);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_regs.sv
// Sample delay line and coefficient file with a tap-indexed read mux.
module fir_tap_regs
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned KW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  input  logic          coef_we,
  input  logic [KW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  input  logic [KW-1:0] k,
  output logic [DW-1:0] x_k,
  output logic [CW-1:0] c_k
);

  logic [DW-1:0] x [TAPS];
  logic [CW-1:0] c [TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      // Flush has priority; the caller already suppresses shift when flushing.
      if (flush) begin
        for (int unsigned i = 0; i < TAPS; i++) x[i] <= '0;
      end else if (shift) begin
        x[0] <= in_data;
        for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end
      if (coef_we) c[coef_addr] <= coef_wdata;
    end
  end

  assign x_k = x[k];
  assign c_k = c[k];

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over TAPS cycles.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned AW   = acc_width(TAPS, DW, CW)
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW-1:0]           y,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_wdata,
  output logic                    coef_err,
  input  logic                    flush
);

  localparam int unsigned KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST   = KW'(TAPS - 1);
  localparam logic [KW:0]   TAPS_EXT = (KW + 1)'(TAPS);

  state_t state, state_nx;
  logic [KW-1:0]    k;
  logic [AW-1:0]    acc, acc_sum;
  logic [DW+CW-1:0] prod;
  logic [DW-1:0]    x_k;
  logic [CW-1:0]    c_k;
  logic             accept, flush_idle, coef_ok, coef_wr;

  fir_tap_regs #(
    .TAPS(TAPS),
    .DW  (DW),
    .CW  (CW),
    .KW  (KW)
  ) u_taps (
    .clk       (ph1),
    .reset     (reset),
    .shift     (accept),
    .in_data   (in_data),
    .flush     (flush_idle),
    .coef_we   (coef_wr),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .k         (k),
    .x_k       (x_k),
    .c_k       (c_k)
  );

  always_comb begin
    in_ready   = (state == IDLE) && !reset;
    out_valid  = (state == DONE);
    flush_idle = flush && (state == IDLE);
    // A flush in the same cycle as an offered sample discards the sample.
    accept     = in_valid && in_ready && !flush;
    coef_ok    = (state == IDLE) && ({1'b0, coef_addr} < TAPS_EXT);
    coef_wr    = coef_we && coef_ok;
    prod       = (DW + CW)'(x_k) * (DW + CW)'(c_k);
    acc_sum    = acc + AW'(prod);

    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (k == K_LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      acc      <= '0;
      y        <= '0;
      coef_err <= 1'b0;
    end else begin
      state    <= state_nx;
      coef_err <= coef_we && !coef_ok;
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        k   <= k + KW'(1);
        if (k == K_LAST) y <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised scoreboard bench for fir_mac_seq against a sum-of-products model.
module tb_fir_mac_seq;

  localparam int unsigned TAPS = 4;
  localparam int unsigned AW   = 18;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic          reset, in_valid, out_ready, coef_we, flush;
  logic [7:0]    in_data, coef_wdata;
  logic [1:0]    coef_addr;
  logic          in_ready, out_valid, coef_err;
  logic [AW-1:0] y;

  logic          t3_in_valid, t3_out_ready, t3_coef_we, t3_flush;
  logic [7:0]    t3_in_data, t3_coef_wdata;
  logic [1:0]    t3_coef_addr;
  logic          t3_in_ready, t3_out_valid, t3_coef_err;
  logic [17:0]   t3_y;

  fir_mac_seq #(.TAPS(4), .DW(8), .CW(8)) u_dut (
    .ph1(ph1), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .flush(flush)
  );

  fir_mac_seq #(.TAPS(3), .DW(8), .CW(8)) u_dut3 (
    .ph1(ph1), .reset(reset), .in_valid(t3_in_valid), .in_ready(t3_in_ready),
    .in_data(t3_in_data), .out_valid(t3_out_valid), .out_ready(t3_out_ready), .y(t3_y),
    .coef_we(t3_coef_we), .coef_addr(t3_coef_addr), .coef_wdata(t3_coef_wdata),
    .coef_err(t3_coef_err), .flush(t3_flush)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;
  logic [63:0] last_exp = '0;
  logic [63:0] mon_exp;

  // Reference model: coefficient table and newest-first sample history.
  longint unsigned m_coef [TAPS];
  longint unsigned m_hist [$];
  logic [63:0]     exp_q  [$];

  always @(posedge ph1) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_y();
    longint unsigned s = 0;
    for (int i = 0; i < TAPS; i++) s += m_coef[i] * m_hist[i];
    return 64'(s);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = 0;
      m_hist.push_back(0);
    end
    exp_q.delete();
  endtask

  task automatic model_flush();
    for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
  endtask

  always @(negedge ph1) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_y", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("y", 64'(y), mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic write_coef(input int unsigned addr, input int unsigned data, input bit expect_err);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_wdata = 8'(data);
    tick();
    coef_we = 1'b0;
    if (!expect_err) m_coef[addr] = data;
    @(negedge ph1);
    check("coef_err", 64'(coef_err), 64'(expect_err));
    tick();
    @(negedge ph1);
    check("coef_err_one_cycle", 64'(coef_err), 64'd0);
    tick();
  endtask

  task automatic start_sample(input int unsigned s);
    bit got = 1'b0;
    in_data = 8'(s); in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge ph1);
      if (in_ready) got = 1'b1;
      else tick();
    end
    check("accept_timeout", 64'(got), 64'd1);
    if (got) begin
      m_hist.push_front(s);
      void'(m_hist.pop_back());
      last_exp = model_y();
      exp_q.push_back(last_exp);
    end
    tick();
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic finish_sample(input int unsigned stall);
    bit seen = 1'b0;
    out_ready = (stall == 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ph1);
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("out_valid_timeout", 64'(seen), 64'd1);
    check("latency", 64'(cyc - acc_cyc), 64'(TAPS));
    if (stall > 0) in_valid = 1'b1;
    for (int j = 0; j < int'(stall); j++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_y", 64'(y), last_exp);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      in_data = 8'($urandom_range(0, 255));
      tick();
      if (j == int'(stall) - 1) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge ph1);
    end
    tick();
    @(negedge ph1);
    check("idle_after_take", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic run_sample(input int unsigned s, input int unsigned stall);
    start_sample(s);
    finish_sample(stall);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t3_seen;
    int unsigned t3_cyc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; coef_we = 1'b0; flush = 1'b0;
    in_data = '0; coef_wdata = '0; coef_addr = '0;
    t3_in_valid = 1'b0; t3_out_ready = 1'b1; t3_coef_we = 1'b0; t3_flush = 1'b0;
    t3_in_data = '0; t3_coef_wdata = '0; t3_coef_addr = '0;
    model_reset();

    tick(); tick();
    @(negedge ph1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_coef_err", 64'(coef_err), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge ph1);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    tick();

    // Impulse response with c = {1,2,3,4}.
    for (int i = 0; i < 4; i++) write_coef(i, i + 1, 1'b0);
    run_sample(1, 0);
    for (int i = 0; i < 4; i++) run_sample(0, 0);

    // Full-scale inputs and coefficients: no wrap at 0x3F804.
    for (int i = 0; i < 4; i++) write_coef(i, 255, 1'b0);
    for (int i = 0; i < 4; i++) run_sample(255, 0);
    check("full_scale_model", last_exp, 64'd260100);

    // Back-pressure in DONE with stray in_valid.
    run_sample(17, 6);

    // Write during MAC is rejected; result uses the old c[2].
    write_coef(2, 40, 1'b0);
    start_sample(10);
    write_coef(2, 9, 1'b1);
    finish_sample(0);
    run_sample(0, 0);

    // Reset in the second MAC cycle aborts with no output.
    start_sample(9);
    tick();
    reset = 1'b1;
    tick();
    @(negedge ph1);
    check("abort_in_ready_in_reset", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    model_reset();
    @(negedge ph1);
    check("abort_ready_after", 64'(in_ready), 64'd1);
    check("abort_y_cleared", 64'(y), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge ph1);
      check("abort_no_partial", 64'(out_valid), 64'd0);
    end
    tick();
    run_sample(1, 0);

    // Flush in IDLE, then flush colliding with an offered sample.
    write_coef(0, 3, 1'b0); write_coef(1, 5, 1'b0);
    write_coef(2, 7, 1'b0); write_coef(3, 11, 1'b0);
    run_sample(5, 0); run_sample(6, 0); run_sample(7, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge ph1);
    check("flush_stays_idle", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge ph1);
      check("flush_drop_no_valid", 64'(out_valid), 64'd0);
    end
    tick();
    run_sample(1, 0);
    check("flush_impulse_model", last_exp, 64'd3);

    // Randomised traffic with coefficient updates, flushes and back-pressure.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0)
        write_coef($urandom_range(0, 3), $urandom_range(0, 255), 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
      end
      run_sample($urandom_range(0, 255), $urandom_range(0, 3));
    end

    // TAPS=3 instance: out-of-range address rejected, valid write kept.
    t3_coef_we = 1'b1; t3_coef_addr = 2'd3; t3_coef_wdata = 8'd7;
    tick();
    t3_coef_we = 1'b0;
    @(negedge ph1);
    check("t3_addr_err", 64'(t3_coef_err), 64'd1);
    tick();
    @(negedge ph1);
    check("t3_addr_err_one_cycle", 64'(t3_coef_err), 64'd0);
    t3_coef_we = 1'b1; t3_coef_addr = 2'd0; t3_coef_wdata = 8'd5;
    tick();
    t3_coef_we = 1'b0;
    @(negedge ph1);
    check("t3_valid_write", 64'(t3_coef_err), 64'd0);
    check("t3_in_ready", 64'(t3_in_ready), 64'd1);
    t3_in_valid = 1'b1; t3_in_data = 8'd2;
    tick();
    t3_in_valid = 1'b0;
    t3_cyc = cyc;
    t3_seen = 1'b0;
    for (int i = 0; i < 40 && !t3_seen; i++) begin
      @(negedge ph1);
      if (t3_out_valid) t3_seen = 1'b1;
      else tick();
    end
    check("t3_out_valid_timeout", 64'(t3_seen), 64'd1);
    check("t3_latency", 64'(cyc - t3_cyc), 64'd3);
    check("t3_y", 64'(t3_y), 64'd10);
    tick();

    tick(); tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
